alu_share_controller: RTL

Sequencing controller that shares one `ALU_RV32I` instance among `REQS` requesters, such as cores or vector lanes. It round-robin arbitrates incoming operation requests and registers the operands. It drives the shared ALU for a per-op number of cycles, since the multiply, divide and remainder paths are multi-cycle, and returns the result to the winning requester with a valid/ready handshake. Divide/remainder by zero is resolved here with RISC-V semantics, independent of the ALU.

---
 rtl/alu_share_controller.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/alu_share_controller.sv
// Shares one RV32I ALU among REQS requesters: round-robin accept, timed EXEC,
// then a held response to the winner. Divide/remainder by zero is resolved locally.
module alu_share_controller #(
  parameter int unsigned N          = 32,
  parameter int unsigned REQS       = 4,
  parameter int unsigned MULDIV_LAT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [REQS-1:0]     req_valid,
  input  logic [4*REQS-1:0]   req_op,
  input  logic [N*REQS-1:0]   req_a,
  input  logic [N*REQS-1:0]   req_b,
  output logic [REQS-1:0]     req_ready,
  output logic [REQS-1:0]     resp_valid,
  input  logic [REQS-1:0]     resp_ready,
  output logic [N-1:0]        resp_o,
  output logic [3:0]          alu_op,
  output logic [N-1:0]        alu_a,
  output logic [N-1:0]        alu_b,
  input  logic [N-1:0]        alu_o,
  output logic                busy
);

  localparam int unsigned PTR_W = (REQS > 1) ? $clog2(REQS) : 1;
  localparam int unsigned CNT_W = $clog2(MULDIV_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;

  state_e             state_q;
  logic [PTR_W-1:0]   rr_ptr_q;
  logic [PTR_W-1:0]   owner_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [3:0]         op_q;
  logic [N-1:0]       a_q;
  logic [N-1:0]       b_q;
  logic [N-1:0]       res_q;
  logic [REQS-1:0]    resp_valid_q;
  logic               busy_q;

  logic [2*REQS-1:0]  rot;
  logic [PTR_W:0]     sum;
  logic               found;
  logic [PTR_W-1:0]   winner;
  logic [3:0]         w_op;
  logic [N-1:0]       w_a;
  logic [N-1:0]       w_b;
  logic [CNT_W-1:0]   w_lat;
  logic [N-1:0]       res_sel;
  logic               accept;

  // Round-robin: first valid requester at or above rr_ptr, wrapping modulo REQS.
  always_comb begin
    rot    = {req_valid, req_valid} >> rr_ptr_q;
    found  = 1'b0;
    sum    = '0;
    winner = '0;
    for (int i = 0; i < int'(REQS); i++) begin
      if (rot[i] && !found) begin
        found = 1'b1;
        sum   = (PTR_W+1)'(rr_ptr_q) + (PTR_W+1)'(i);
      end
    end
    if (sum >= (PTR_W+1)'(REQS)) begin
      sum = sum - (PTR_W+1)'(REQS);
    end
    winner = PTR_W'(sum);
  end

  always_comb begin
    w_op = '0;
    w_a  = '0;
    w_b  = '0;
    for (int i = 0; i < int'(REQS); i++) begin
      if (PTR_W'(i) == winner) begin
        w_op = req_op[4*i +: 4];
        w_a  = req_a[N*i +: N];
        w_b  = req_b[N*i +: N];
      end
    end
    w_lat = (w_op >= 4'd13) ? CNT_W'(MULDIV_LAT) : CNT_W'(1);
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && state_q == S_IDLE && found) begin
      req_ready = REQS'(1) << winner;
    end
  end

  assign accept = |(req_ready & req_valid);

  // RISC-V divide-by-zero results override whatever the ALU produces.
  always_comb begin
    res_sel = alu_o;
    if (op_q == 4'd14 && b_q == '0) begin
      res_sel = '1;
    end else if (op_q == 4'd15 && b_q == '0) begin
      res_sel = a_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      cnt_q        <= '0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      resp_valid_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q     <= w_op;
            a_q      <= w_a;
            b_q      <= w_b;
            owner_q  <= winner;
            rr_ptr_q <= (winner == PTR_W'(REQS - 1)) ? '0 : winner + PTR_W'(1);
            cnt_q    <= w_lat;
            busy_q   <= 1'b1;
            state_q  <= S_EXEC;
          end
        end
        S_EXEC: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            res_q        <= res_sel;
            resp_valid_q <= REQS'(1) << owner_q;
            state_q      <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_ready[owner_q]) begin
            resp_valid_q <= '0;
            busy_q       <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // ALU operands come straight from the operand registers, so they only move on accept.
  assign alu_op     = op_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign resp_o     = res_q;
  assign resp_valid = resp_valid_q;
  assign busy       = busy_q;

endmodule
